// File: rtl/fltadd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fltadd_pkg
// Description : Shared constants, field widths and state encoding for the
//               fp16 add memory engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fltadd_pkg;

    localparam int c_EXP_W  = 5;
    localparam int c_FRAC_W = 10;
    localparam int c_MANT_W = c_FRAC_W + 1;

    localparam logic [7:0] c_OP1_ADDR = 8'd8;
    localparam logic [7:0] c_OP2_ADDR = 8'd10;
    localparam logic [7:0] c_RES_ADDR = 8'd12;

    localparam logic [c_EXP_W-1:0] c_EXP_SAT = 5'h1F;

    typedef logic [3:0] state_t;
    localparam state_t c_S_IDLE  = 4'd0;
    localparam state_t c_S_RD1L  = 4'd1;
    localparam state_t c_S_RD1H  = 4'd2;
    localparam state_t c_S_RD2L  = 4'd3;
    localparam state_t c_S_RD2H  = 4'd4;
    localparam state_t c_S_CMP   = 4'd5;
    localparam state_t c_S_ALIGN = 4'd6;
    localparam state_t c_S_ADD   = 4'd7;
    localparam state_t c_S_NORM  = 4'd8;
    localparam state_t c_S_WRL   = 4'd9;
    localparam state_t c_S_WRH   = 4'd10;
    localparam state_t c_S_DONE  = 4'd11;

endpackage
`default_nettype wire

// File: rtl/fltadd_mem_engine_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp16_unpack
// Description : Splits an fp16 word into sign, exponent and 11-bit mantissa
//               carrying the implicit leading one.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_unpack
    import fltadd_pkg::*;
(
    input  logic [15:0]         i_word,
    output logic                o_sign,
    output logic [c_EXP_W-1:0]  o_exp,
    output logic [c_MANT_W-1:0] o_mant
);

    assign o_sign = i_word[15];
    assign o_exp  = i_word[14:10];
    // Exponent zero keeps a zero hidden bit; no denormal exponent adjust.
    assign o_mant = {|i_word[14:10], i_word[9:0]};

endmodule
`default_nettype wire

// File: rtl/fltadd_mem_engine.sv
`default_nettype none
// ============================================================================
// Module      : fltadd_mem_engine
// Description : fp16 add engine mastering a byte-wide memory: reads two
//               operands, adds with truncation, writes the sum, raises Done.
// Revision    : 1.0 - initial release
// ============================================================================
module fltadd_mem_engine
    import fltadd_pkg::*;
#(
    parameter logic [7:0] OP1_ADDR  = c_OP1_ADDR,
    parameter logic [7:0] OP2_ADDR  = c_OP2_ADDR,
    parameter logic [7:0] RES_ADDR  = c_RES_ADDR,
    parameter int         MAX_SHIFT = 11
)
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Done,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic       MemWrEn,
    output logic [7:0] MemWrData
);

    localparam logic [c_EXP_W-1:0] c_MAX_SHIFT = MAX_SHIFT[c_EXP_W-1:0];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_flt1;
    logic [15:0]           r_flt2;
    logic                  r_sign;
    logic [c_EXP_W-1:0]    r_exp_a;
    logic [c_MANT_W-1:0]   r_mant_a;
    logic [c_MANT_W-1:0]   r_mant_b;
    logic [c_EXP_W-1:0]    r_cnt;
    logic [c_MANT_W:0]     r_sum;
    logic [15:0]           r_result;

    logic                  w_sign1;
    logic                  w_unused_sign2;
    logic [c_EXP_W-1:0]    w_exp1;
    logic [c_EXP_W-1:0]    w_exp2;
    logic [c_MANT_W-1:0]   w_mant1;
    logic [c_MANT_W-1:0]   w_mant2;
    logic                  w_a_is_1;
    logic [c_EXP_W-1:0]    w_diff;
    logic [c_EXP_W-1:0]    w_shift;
    logic [c_EXP_W:0]      w_norm_exp;
    logic [c_FRAC_W-1:0]   w_norm_frac;
    logic [15:0]           w_result;

    fp16_unpack u_unpack1 (
        .i_word (r_flt1),
        .o_sign (w_sign1),
        .o_exp  (w_exp1),
        .o_mant (w_mant1)
    );

    fp16_unpack u_unpack2 (
        .i_word (r_flt2),
        .o_sign (w_unused_sign2),
        .o_exp  (w_exp2),
        .o_mant (w_mant2)
    );

    // Ties keep operand 1 as the larger-exponent operand.
    assign w_a_is_1 = (w_exp1 >= w_exp2);
    assign w_diff   = w_a_is_1 ? (w_exp1 - w_exp2) : (w_exp2 - w_exp1);
    assign w_shift  = (w_diff >= c_MAX_SHIFT) ? c_MAX_SHIFT : w_diff;

    always_comb begin
        w_norm_exp  = {1'b0, r_exp_a};
        w_norm_frac = r_sum[c_FRAC_W-1:0];
        if (r_sum[c_MANT_W]) begin
            w_norm_exp  = {1'b0, r_exp_a} + 6'd1;
            w_norm_frac = r_sum[c_FRAC_W:1];
        end else if ((r_exp_a == '0) && r_sum[c_FRAC_W]) begin
            w_norm_exp = 6'd1;
        end
        if (w_norm_exp >= {1'b0, c_EXP_SAT}) begin
            w_result = {r_sign, c_EXP_SAT, 10'h000};
        end else begin
            w_result = {r_sign, w_norm_exp[c_EXP_W-1:0], w_norm_frac};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (Start) w_state_nxt = c_S_RD1L;
            c_S_RD1L:  w_state_nxt = c_S_RD1H;
            c_S_RD1H:  w_state_nxt = c_S_RD2L;
            c_S_RD2L:  w_state_nxt = c_S_RD2H;
            c_S_RD2H:  w_state_nxt = c_S_CMP;
            c_S_CMP:   w_state_nxt = (w_shift != '0) ? c_S_ALIGN : c_S_ADD;
            c_S_ALIGN: w_state_nxt = (r_cnt <= 5'd1) ? c_S_ADD : c_S_ALIGN;
            c_S_ADD:   w_state_nxt = c_S_NORM;
            c_S_NORM:  w_state_nxt = c_S_WRL;
            c_S_WRL:   w_state_nxt = c_S_WRH;
            c_S_WRH:   w_state_nxt = c_S_DONE;
            c_S_DONE:  if (Start) w_state_nxt = c_S_RD1L;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        MemAddr   = 8'd0;
        MemWrEn   = 1'b0;
        MemWrData = 8'd0;
        Done      = 1'b0;
        case (r_state)
            c_S_RD1L: MemAddr = OP1_ADDR;
            c_S_RD1H: MemAddr = OP1_ADDR + 8'd1;
            c_S_RD2L: MemAddr = OP2_ADDR;
            c_S_RD2H: MemAddr = OP2_ADDR + 8'd1;
            c_S_WRL: begin
                MemAddr   = RES_ADDR;
                MemWrEn   = 1'b1;
                MemWrData = r_result[7:0];
            end
            c_S_WRH: begin
                MemAddr   = RES_ADDR + 8'd1;
                MemWrEn   = 1'b1;
                MemWrData = r_result[15:8];
            end
            c_S_DONE: Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= c_S_IDLE;
            r_flt1   <= '0;
            r_flt2   <= '0;
            r_sign   <= 1'b0;
            r_exp_a  <= '0;
            r_mant_a <= '0;
            r_mant_b <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_S_RD1L: r_flt1[7:0]  <= MemRdData;
                c_S_RD1H: r_flt1[15:8] <= MemRdData;
                c_S_RD2L: r_flt2[7:0]  <= MemRdData;
                c_S_RD2H: r_flt2[15:8] <= MemRdData;
                c_S_CMP: begin
                    r_sign   <= w_sign1;
                    r_exp_a  <= w_a_is_1 ? w_exp1  : w_exp2;
                    r_mant_a <= w_a_is_1 ? w_mant1 : w_mant2;
                    r_mant_b <= w_a_is_1 ? w_mant2 : w_mant1;
                    r_cnt    <= w_shift;
                end
                c_S_ALIGN: begin
                    // A capped difference drops the smaller operand entirely.
                    if (r_cnt == c_MAX_SHIFT) begin
                        r_mant_b <= '0;
                    end else begin
                        r_mant_b <= r_mant_b >> 1;
                    end
                    r_cnt <= r_cnt - 5'd1;
                end
                c_S_ADD:  r_sum    <= {1'b0, r_mant_a} + {1'b0, r_mant_b};
                c_S_NORM: r_result <= w_result;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fltadd_mem_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_fltadd_mem_engine
// Description : Self-checking bench for fltadd_mem_engine against an
//               arithmetic fp16 truncating-add model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fltadd_mem_engine;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Done;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic       MemWrEn;
    logic [7:0] MemWrData;

    logic [7:0] rd_mem [256];
    logic [7:0] wr_mem [256];
    int         wr_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    fltadd_mem_engine dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Done      (Done),
        .MemAddr   (MemAddr),
        .MemRdData (MemRdData),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRdData = rd_mem[MemAddr];

    always @(posedge Clk) begin
        if (MemWrEn === 1'b1) begin
            wr_mem[MemAddr] = MemWrData;
            wr_cnt = wr_cnt + 1;
        end
    end

    function automatic int min_shift(input logic [15:0] f1, input logic [15:0] f2);
        int e1, e2, d;
        e1 = int'(f1[14:10]);
        e2 = int'(f2[14:10]);
        d  = (e1 >= e2) ? e1 - e2 : e2 - e1;
        return (d > 11) ? 11 : d;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] f1, input logic [15:0] f2);
        int e1, e2, m1, m2, ea, ma, mb, d, s, e;
        logic [4:0] ebits;
        logic [9:0] fbits;
        e1 = int'(f1[14:10]);
        e2 = int'(f2[14:10]);
        m1 = int'(f1[9:0]) + ((e1 != 0) ? 1024 : 0);
        m2 = int'(f2[9:0]) + ((e2 != 0) ? 1024 : 0);
        if (e1 >= e2) begin
            ea = e1; ma = m1; mb = m2; d = e1 - e2;
        end else begin
            ea = e2; ma = m2; mb = m1; d = e2 - e1;
        end
        mb = (d >= 11) ? 0 : mb / (1 << d);
        s  = ma + mb;
        if (s >= 2048) begin
            s = s / 2;
            e = ea + 1;
        end else if (ea == 0 && s >= 1024) begin
            e = 1;
        end else begin
            e = ea;
        end
        if (e >= 31) return {f1[15], 5'h1F, 10'h000};
        ebits = e[4:0];
        fbits = s[9:0];
        return {f1[15], ebits, fbits};
    endfunction

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        rd_mem[8]  = a[7:0];
        rd_mem[9]  = a[15:8];
        rd_mem[10] = b[7:0];
        rd_mem[11] = b[15:8];
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string name);
        int          cyc;
        int          w0;
        int          lat;
        logic [15:0] exp_res;
        logic [15:0] got;
        load_ops(a, b);
        exp_res = ref_add(a, b);
        lat     = 9 + min_shift(a, b);
        w0      = wr_cnt;
        Start   = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_after_start: got %b want 0", name, Done);
        end
        cyc = 0;
        while (Done !== 1'b1 && cyc < 60) begin
            @(posedge Clk); #1;
            cyc++;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: Done=%b after %0d cycles", name, Done, cyc);
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        got = {wr_mem[13], wr_mem[12]};
        checks++;
        if (got !== exp_res) begin
            errors++;
            $display("FAIL %s result a=%h b=%h: got %h want %h", name, a, b, got, exp_res);
        end
        checks++;
        if (wr_cnt - w0 != 2) begin
            errors++;
            $display("FAIL %s write_count: got %0d want 2", name, wr_cnt - w0);
        end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b1 || wr_cnt - w0 != 2) begin
            errors++;
            $display("FAIL %s done_hold: Done=%b writes=%0d want 1/2", name, Done, wr_cnt - w0);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0 || MemWrEn !== 1'b0 || MemAddr !== 8'd0 || MemWrData !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: Done=%b WrEn=%b Addr=%h WrData=%h want 0/0/00/00",
                     Done, MemWrEn, MemAddr, MemWrData);
        end
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL idle_quiet: Done=%b writes=%0d want 0/0", Done, wr_cnt);
        end
    endtask

    task automatic test_directed();
        run_op(16'h1A04, 16'h1A04, "equal_exp_carry");
        run_op(16'h4204, 16'h5604, "diff5_swap");
        run_op(16'h7BFF, 16'h7BFF, "overflow_sat");
        run_op(16'h3C00, 16'h0400, "shift_cap");
        run_op(16'h8400, 16'h0400, "sign_of_op1");
        run_op(16'h0300, 16'h0200, "denorm_promote");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 3 == 0) b[14:10] = a[14:10] - 5'(i % 4);
            run_op(a, b, "random");
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] lo;
        logic [7:0] hi;
        int         w0;
        load_ops(16'h4204, 16'h5604);
        lo = wr_mem[12];
        hi = wr_mem[13];
        w0 = wr_cnt;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0 || MemWrEn !== 1'b0 || MemAddr !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: Done=%b WrEn=%b Addr=%h want 0/0/00", Done, MemWrEn, MemAddr);
        end
        Reset = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0 || wr_cnt != w0 || wr_mem[12] !== lo || wr_mem[13] !== hi) begin
            errors++;
            $display("FAIL mid_reset_abort: Done=%b writes=%0d bytes=%h%h want 0/0/%h%h",
                     Done, wr_cnt - w0, wr_mem[13], wr_mem[12], hi, lo);
        end
        run_op(16'h4204, 16'h5604, "restart_after_reset");
    endtask

    task automatic test_back_to_back();
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_precondition: Done=%b want 1", Done);
        end
        run_op(16'h1A04, 16'h1C04, "back_to_back");
        run_op(16'h5604, 16'h4204, "back_to_back_2");
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
